// File: rtl/match_event_logger.sv
// Counts, timestamps and gap-measures detector matches; each match is pushed into a show-ahead FIFO
// visible right after its edge; a full FIFO with no coincident pop drops the record and sets sticky overflow.
module match_event_logger #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in,
    input  logic                       clr,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [TS_W-1:0]            rec_ts,
    output logic [TS_W-1:0]            rec_gap,
    output logic [CNT_W-1:0]           match_count,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_gc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [LW-1:0]    r_level;
    logic [TS_W-1:0]  r_mem_ts  [DEPTH];
    logic [TS_W-1:0]  r_mem_gap [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_pop   = !w_empty && rec_ready;
    // A full FIFO still accepts the new record when the head leaves in the same cycle.
    assign w_push  = in && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts    <= '0;
            r_gc    <= '1;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_ts[i]  <= '0;
                r_mem_gap[i] <= '0;
            end
        end else if (clr) begin
            r_ts    <= '0;
            r_gc    <= '1;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_ts[i]  <= '0;
                r_mem_gap[i] <= '0;
            end
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (in) begin
                r_gc <= TS_W'(1);
                if (r_cnt != '1)
                    r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_gc != '1) begin
                r_gc <= r_gc + TS_W'(1);
            end
            if (in && !w_push)
                r_ovf <= 1'b1;
            if (w_push) begin
                r_mem_ts[r_wp]  <= r_ts;
                r_mem_gap[r_wp] <= r_gc;
                r_wp            <= r_wp + AW'(1);
            end
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - LW'(1);
        end
    end

    assign rec_valid   = !w_empty;
    assign rec_ts      = w_empty ? '0 : r_mem_ts[r_rp];
    assign rec_gap     = w_empty ? '0 : r_mem_gap[r_rp];
    assign match_count = r_cnt;
    assign overflow    = r_ovf;
    assign fifo_level  = r_level;
endmodule

// File: tb/tb_match_event_logger.sv
// Directed bench: a 16-bit-timestamp instance for most scenarios and a 4-bit one for wrap/saturation.
module tb_match_event_logger;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        rec_ready;
    logic        in_a;
    logic        in_b;

    logic        a_valid, a_ovf;
    logic [15:0] a_ts, a_gap, a_cnt;
    logic [2:0]  a_level;

    logic        b_valid, b_ovf;
    logic [3:0]  b_ts, b_gap;
    logic [15:0] b_cnt;
    logic [2:0]  b_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    match_event_logger #(.CNT_W(16), .TS_W(16), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .in(in_a), .clr(clr),
        .rec_valid(a_valid), .rec_ready(rec_ready),
        .rec_ts(a_ts), .rec_gap(a_gap), .match_count(a_cnt),
        .overflow(a_ovf), .fifo_level(a_level)
    );

    match_event_logger #(.CNT_W(16), .TS_W(4), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in(in_b), .clr(clr),
        .rec_valid(b_valid), .rec_ready(rec_ready),
        .rec_ts(b_ts), .rec_gap(b_gap), .match_count(b_cnt),
        .overflow(b_ovf), .fifo_level(b_level)
    );

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; rec_ready = 1'b0; in_a = 1'b0; in_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_a = ~in_a;
            in_b = ~in_b;
            step();
        end
        checks++; if (a_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %0d want 0", a_valid); end
        checks++; if (a_ts !== 16'h0)    begin errors++; $display("FAIL reset_ts got %h want 0000", a_ts); end
        checks++; if (a_gap !== 16'h0)   begin errors++; $display("FAIL reset_gap got %h want 0000", a_gap); end
        checks++; if (a_cnt !== 16'h0)   begin errors++; $display("FAIL reset_count got %0d want 0", a_cnt); end
        checks++; if (a_ovf !== 1'b0)    begin errors++; $display("FAIL reset_overflow got %0d want 0", a_ovf); end
        checks++; if (a_level !== 3'd0)  begin errors++; $display("FAIL reset_level got %0d want 0", a_level); end
        checks++; if (b_level !== 3'd0)  begin errors++; $display("FAIL reset_level4 got %0d want 0", b_level); end
        in_a = 1'b0; in_b = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_spaced();
        for (int i = 0; i < 5; i++) step();
        in_a = 1'b1; step();
        checks++; if (a_valid !== 1'b1 || a_ts !== 16'd5 || a_gap !== 16'hFFFF)
            begin errors++; $display("FAIL first_record got v=%0d ts=%h gap=%h want v=1 ts=0005 gap=ffff", a_valid, a_ts, a_gap); end
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL count_after_one got %0d want 1", a_cnt); end
        in_a = 1'b0; step(); step();
        in_a = 1'b1; step();
        in_a = 1'b0;
        checks++; if (a_level !== 3'd2) begin errors++; $display("FAIL spaced_level got %0d want 2", a_level); end
        checks++; if (a_cnt !== 16'd2)  begin errors++; $display("FAIL spaced_count got %0d want 2", a_cnt); end
        checks++; if (a_ts !== 16'd5 || a_gap !== 16'hFFFF)
            begin errors++; $display("FAIL spaced_head got ts=%h gap=%h want 0005/ffff", a_ts, a_gap); end
    endtask

    task automatic test_drain();
        rec_ready = 1'b1; step();
        checks++; if (a_ts !== 16'd8 || a_gap !== 16'd3 || a_level !== 3'd1)
            begin errors++; $display("FAIL drain_second got ts=%h gap=%h lvl=%0d want 0008/0003/1", a_ts, a_gap, a_level); end
        step();
        checks++; if (a_valid !== 1'b0 || a_ts !== 16'd0 || a_gap !== 16'd0 || a_level !== 3'd0)
            begin errors++; $display("FAIL drain_empty got v=%0d ts=%h gap=%h lvl=%0d want 0/0000/0000/0", a_valid, a_ts, a_gap, a_level); end
        rec_ready = 1'b0;
    endtask

    task automatic test_overflow();
        clr = 1'b1; step(); clr = 1'b0;
        in_a = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++; if (a_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", a_level); end
        checks++; if (a_cnt !== 16'd6)  begin errors++; $display("FAIL ovf_count got %0d want 6", a_cnt); end
        checks++; if (a_ovf !== 1'b1)   begin errors++; $display("FAIL ovf_flag got %0d want 1", a_ovf); end
        checks++; if (a_ts !== 16'd0 || a_gap !== 16'hFFFF)
            begin errors++; $display("FAIL ovf_oldest got ts=%h gap=%h want 0000/ffff", a_ts, a_gap); end
        rec_ready = 1'b1; step();
        in_a = 1'b0;
        checks++; if (a_level !== 3'd4 || a_ovf !== 1'b1 || a_cnt !== 16'd7)
            begin errors++; $display("FAIL full_pushpop got lvl=%0d ovf=%0d cnt=%0d want 4/1/7", a_level, a_ovf, a_cnt); end
        checks++; if (a_ts !== 16'd1 || a_gap !== 16'd1)
            begin errors++; $display("FAIL full_pushpop_head got ts=%h gap=%h want 0001/0001", a_ts, a_gap); end
        step(); step(); step();
        checks++; if (a_ts !== 16'd6 || a_gap !== 16'd1 || a_level !== 3'd1)
            begin errors++; $display("FAIL stored_new got ts=%h gap=%h lvl=%0d want 0006/0001/1", a_ts, a_gap, a_level); end
        rec_ready = 1'b0;
        in_a = 1'b1; step(); step();
        in_a = 1'b0;
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0d want 1", a_ovf); end
    endtask

    task automatic test_clear();
        clr = 1'b1; in_a = 1'b1; step();
        clr = 1'b0; in_a = 1'b0;
        checks++; if (a_level !== 3'd0 || a_cnt !== 16'd0 || a_ovf !== 1'b0 || a_valid !== 1'b0)
            begin errors++; $display("FAIL clear got lvl=%0d cnt=%0d ovf=%0d v=%0d want 0/0/0/0", a_level, a_cnt, a_ovf, a_valid); end
        step();
        in_a = 1'b1; step(); in_a = 1'b0;
        checks++; if (a_ts !== 16'd1 || a_gap !== 16'hFFFF || a_cnt !== 16'd1)
            begin errors++; $display("FAIL post_clear got ts=%h gap=%h cnt=%0d want 0001/ffff/1", a_ts, a_gap, a_cnt); end
    endtask

    task automatic test_wrap();
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 20; i++) step();
        in_b = 1'b1; step(); in_b = 1'b0;
        checks++; if (b_ts !== 4'd4 || b_gap !== 4'd15)
            begin errors++; $display("FAIL wrap_first got ts=%0d gap=%0d want 4/15", b_ts, b_gap); end
        for (int i = 0; i < 16; i++) step();
        in_b = 1'b1; step(); in_b = 1'b0;
        checks++; if (b_level !== 3'd2 || b_cnt !== 16'd2)
            begin errors++; $display("FAIL wrap_level got lvl=%0d cnt=%0d want 2/2", b_level, b_cnt); end
        rec_ready = 1'b1; step(); rec_ready = 1'b0;
        checks++; if (b_ts !== 4'd5 || b_gap !== 4'd15)
            begin errors++; $display("FAIL wrap_second got ts=%0d gap=%0d want 5/15", b_ts, b_gap); end
    endtask

    initial begin
        test_reset();
        test_spaced();
        test_drain();
        test_overflow();
        test_clear();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the 11011 Moore sequence detector's `out` bit. It counts matches, timestamps each one, and measures the gap since the previous match. Each match becomes a record in a small show-ahead FIFO, which a host or checker drains through a valid/ready handshake. Records lost to a full FIFO are flagged by a sticky overflow bit.

## Interface
Parameters:
- `CNT_W`, 16, width of the match counter.
- `TS_W`, 16, width of the timestamp counter and of the gap field.
- `DEPTH`, 4, number of FIFO records. Must be a power of two and at least 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in`  in  1  detector match bit (the detector's `out`), sampled on every rising edge.
- `clr`  in  1  synchronous clear of counters, FIFO and overflow.
- `rec_valid`  out  1  FIFO not empty; head record present.
- `rec_ready`  in  1  consumer accepts the head record when `rec_valid` is also high.
- `rec_ts`  out  TS_W  timestamp of the head record.
- `rec_gap`  out  TS_W  gap field of the head record.
- `match_count`  out  CNT_W  total matches since reset/clr. Saturates at all-ones.
- `overflow`  out  1  sticky; a record was dropped.
- `fifo_level`  out  $clog2(DEPTH)+1  number of records held.

## Operation
- Reset values: `rec_valid`=0, `rec_ts`=0, `rec_gap`=0, `match_count`=0, `overflow`=0, `fifo_level`=0. The timestamp counter is 0 and the gap counter is all-ones.
- Event definition: `in`=1 at a rising edge. Every such cycle is one event, including consecutive high cycles.
- Timestamp counter `ts`:
  - free-running, +1 every edge, wraps modulo 2^TS_W.
  - An event's record captures the pre-increment value.
- Gap counter `gc`:
  - On an event, the record captures `gc` and `gc` is then set to 1.
  - Otherwise `gc` increments, saturating at all-ones.
  - The first event after reset or `clr` therefore records gap = all-ones.
- `match_count` increments on every event, whether or not the record is stored, and saturates at all-ones.
- Push: an event writes {ts, gc} into the FIFO if the FIFO is not full.
  - When full, the push still succeeds if a pop happens in the same cycle.
  - Otherwise the record is dropped and `overflow` is set to 1.
- Pop: occurs when `rec_valid` && `rec_ready`. The head advances at that edge.
- A simultaneous push and pop leaves `fifo_level` unchanged.
- The FIFO is show-ahead: `rec_ts`/`rec_gap` always present the head entry. Both read 0 when the FIFO is empty.
- Pointers wrap modulo DEPTH.
- `clr`=1 clears all of the following at that edge, and it overrides a coincident event or pop:
  - FIFO contents/pointers, `fifo_level`, `match_count`, `overflow` and `ts` are zeroed.
  - `gc` is set to all-ones.
- `overflow` clears only on `rst` or `clr`.

## Timing
- Record latency: an event sampled at edge N with the FIFO empty gives `rec_valid`=1 and the head fields valid immediately after edge N.
- `match_count` updates after the same edge N.
- Throughput: one push and one pop per cycle.
- `rec_valid` must not depend combinationally on `rec_ready`.
- All outputs are registered or decoded only from registers. There are no combinational paths from `in`.
- Reset is asserted asynchronously. The bench releases it away from the clock edge, and the first edge after release may carry an event.

## Test plan
1. Reset: hold `rst`=1 with `in` toggling. Required: all outputs at reset values, with no records and a count of 0.
2. Spaced matches: pulse `in` at the edges where `ts`=5 and `ts`=8, with `rec_ready`=0.
   - Required: `fifo_level`=2 and `match_count`=2.
   - Records are {ts=5, gap=FFFF} and then {ts=8, gap=3}.
3. Drain: raise `rec_ready` after scenario 2. Required: head {5,FFFF} is popped at the first edge and {8,3} at the second. Then `rec_valid`=0 and fields read 0.
4. Overflow: 6 events with `rec_ready`=0 (DEPTH=4).
   - Required: `fifo_level`=4, `match_count`=6, `overflow`=1.
   - The oldest 4 records are kept.
   - Then, with the FIFO full, raise `rec_ready` and pulse `in` in the same cycle. Required: level stays 4, the new record is stored, and `overflow` stays 1.
5. Clear: with the FIFO non-empty, assert `clr` together with `in`=1.
   - Required: everything zeroed; the coincident event is not counted.
   - The next event records {ts=1 if it is on the second edge after clr, gap=FFFF}.
6. Wrap: with TS_W=4, run 20 idle cycles, then one event, then a second event 17 cycles later.
   - Required: the first record's ts is the wrapped value 20 mod 16 = 4.
   - The second record's gap=15 (saturated) and its ts=(4+17) mod 16 = 5.
